// File: rtl/fir_stream_core_if.sv
// Sample stream, coefficient write port and filtered result of fir_stream_core.
// The slave modport is the filter; the master drives samples and coefficients.
interface fir_stream_core_if #(
    parameter int TAPS   = 32,
    parameter int DATA_W = 16,
    parameter int COEF_W = 20,
    parameter int OUT_W  = 16
);
    localparam int ADDR_W = $clog2(TAPS);

    logic                     data_valid;
    logic signed [DATA_W-1:0] data;
    logic                     clear;
    logic                     coef_we;
    logic [ADDR_W-1:0]        coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     fir_valid;
    logic signed [OUT_W-1:0]  fir_d;
    logic                     sat_flag;

    modport master (
        output data_valid, data, clear, coef_we, coef_addr, coef_data,
        input  fir_valid, fir_d, sat_flag
    );

    modport slave (
        input  data_valid, data, clear, coef_we, coef_addr, coef_data,
        output fir_valid, fir_d, sat_flag
    );
endinterface

// File: rtl/fir_stream_core.sv
// Direct-form streaming FIR: delay line, full-precision multiply-accumulate stage,
// then scale/round/saturate stage. Output appears two edges after each accepted sample.
module fir_stream_core #(
    parameter int TAPS      = 32,
    parameter int DATA_W    = 16,
    parameter int IN_FRAC   = 8,
    parameter int COEF_W    = 20,
    parameter int COEF_FRAC = 16,
    parameter int OUT_W     = 16,
    parameter int OUT_FRAC  = 8,
    parameter int ROUND     = 0
) (
    input  logic             clk,
    input  logic             rst,
    fir_stream_core_if.slave bus
);
    localparam int ADDR_W = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(TAPS);
    localparam int SHIFT  = IN_FRAC + COEF_FRAC - OUT_FRAC;
    localparam int FILL_W = $clog2(TAPS + 1);

    localparam logic signed [ACC_W:0] RND_CONST =
        (ROUND != 0) ? ((ACC_W + 1)'(1) << (SHIFT - 1)) : '0;

    logic signed [DATA_W-1:0] x_reg    [TAPS];
    logic signed [COEF_W-1:0] coef_reg [TAPS];
    logic signed [PROD_W-1:0] prod     [TAPS];
    logic [TAPS-1:0]          coef_sel;

    logic [FILL_W-1:0]        fill_reg;
    logic                     fill_full;
    logic                     warm_done;

    logic                     v1_reg;
    logic                     v2_reg;
    logic                     fir_valid_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [OUT_W-1:0]  fir_d_reg;
    logic signed [OUT_W-1:0]  fir_d_next;
    logic                     sat_reg;
    logic                     clamp;
    logic signed [ACC_W:0]    rnd_sum;
    logic signed [ACC_W:0]    scaled;

    // Address decode per tap; addresses at or beyond TAPS match no tap and are dropped.
    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
            assign coef_sel[gi] = bus.coef_we && (bus.coef_addr == ADDR_W'(gi));
            assign prod[gi]     = x_reg[gi] * coef_reg[gi];
        end
    endgenerate

    assign fill_full = (fill_reg == FILL_W'(TAPS));
    assign warm_done = (fill_reg >= FILL_W'(TAPS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) begin
                x_reg[k]    <= '0;
                coef_reg[k] <= '0;
            end
            fill_reg <= '0;
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (coef_sel[k]) begin
                    coef_reg[k] <= bus.coef_data;
                end
            end
            // clear wins over a coincident sample, which is simply lost
            if (bus.clear) begin
                for (int k = 0; k < TAPS; k++) begin
                    x_reg[k] <= '0;
                end
                fill_reg <= '0;
            end else if (bus.data_valid) begin
                x_reg[0] <= bus.data;
                for (int k = 1; k < TAPS; k++) begin
                    x_reg[k] <= x_reg[k-1];
                end
                if (!fill_full) begin
                    fill_reg <= fill_reg + 1'b1;
                end
            end
        end
    end

    always_comb begin
        acc_next = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc_next = acc_next + ACC_W'(prod[k]);
        end
    end

    // One guard bit above the accumulator keeps the rounding add from wrapping.
    always_comb begin
        rnd_sum    = {acc_reg[ACC_W-1], acc_reg} + RND_CONST;
        scaled     = rnd_sum >>> SHIFT;
        clamp      = !((&scaled[ACC_W:OUT_W-1]) || !(|scaled[ACC_W:OUT_W-1]));
        fir_d_next = scaled[OUT_W-1:0];
        if (clamp) begin
            fir_d_next = scaled[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                                       : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_reg        <= 1'b0;
            v2_reg        <= 1'b0;
            fir_valid_reg <= 1'b0;
            acc_reg       <= '0;
            fir_d_reg     <= '0;
            sat_reg       <= 1'b0;
        end else begin
            if (bus.clear) begin
                v1_reg        <= 1'b0;
                v2_reg        <= 1'b0;
                fir_valid_reg <= 1'b0;
            end else begin
                v1_reg        <= bus.data_valid && warm_done;
                v2_reg        <= v1_reg;
                fir_valid_reg <= v2_reg;
                if (v2_reg) begin
                    fir_d_reg <= fir_d_next;
                    if (clamp) begin
                        sat_reg <= 1'b1;
                    end
                end
            end
            if (v1_reg) begin
                acc_reg <= acc_next;
            end
        end
    end

    assign bus.fir_valid = fir_valid_reg;
    assign bus.fir_d     = fir_d_reg;
    assign bus.sat_flag  = sat_reg;
endmodule

// File: tb/tb_fir_stream_core.sv
// Bench for fir_stream_core: three instances (32 taps floor, 4 taps round, 5 taps floor)
// share one stimulus stream and are compared every cycle against a sample-history model.
module tb_fir_stream_core;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fir_stream_core_if #(.TAPS(32)) bus_a ();
    fir_stream_core_if #(.TAPS(4))  bus_b ();
    fir_stream_core_if #(.TAPS(5))  bus_c ();

    fir_stream_core #(.TAPS(32), .ROUND(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    fir_stream_core #(.TAPS(4),  .ROUND(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    fir_stream_core #(.TAPS(5),  .ROUND(0)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    logic               dv   = 1'b0;
    logic               clr  = 1'b0;
    logic               cwe  = 1'b0;
    logic signed [15:0] din  = '0;
    logic [7:0]         caddr = '0;
    logic signed [19:0] cdat = '0;

    assign bus_a.data_valid = dv;  assign bus_b.data_valid = dv;  assign bus_c.data_valid = dv;
    assign bus_a.data       = din; assign bus_b.data       = din; assign bus_c.data       = din;
    assign bus_a.clear      = clr; assign bus_b.clear      = clr; assign bus_c.clear      = clr;
    assign bus_a.coef_data  = cdat; assign bus_b.coef_data = cdat; assign bus_c.coef_data = cdat;
    assign bus_a.coef_we    = cwe;
    assign bus_b.coef_we    = cwe && (caddr < 8'd4);
    assign bus_c.coef_we    = cwe;
    assign bus_a.coef_addr  = caddr[4:0];
    assign bus_b.coef_addr  = caddr[1:0];
    assign bus_c.coef_addr  = caddr[2:0];

    logic        ov [ND];
    logic [15:0] od [ND];
    logic        os [ND];
    assign ov[0] = bus_a.fir_valid; assign od[0] = bus_a.fir_d; assign os[0] = bus_a.sat_flag;
    assign ov[1] = bus_b.fir_valid; assign od[1] = bus_b.fir_d; assign os[1] = bus_b.sat_flag;
    assign ov[2] = bus_c.fir_valid; assign od[2] = bus_c.fir_d; assign os[2] = bus_c.sat_flag;

    // Reference model: per instance, history of accepted samples and coefficient table.
    int taps_m [ND] = '{32, 4, 5};
    int rnd_m  [ND] = '{0, 1, 0};
    int aw_m   [ND] = '{5, 2, 3};
    longint      hist   [ND][64];
    longint      cm     [ND][64];
    int          fill_m [ND];
    bit          sat_m  [ND];
    logic [15:0] fd_m   [ND];

    typedef struct {
        int          d;
        int          due;
        logic [15:0] val;
        bit          clamp;
    } pend_t;
    pend_t pq[$];

    logic [15:0] cap_b[$];
    int pulses [ND];
    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] d;
        logic [19:0] c0;
        logic [15:0] q_floor;
        logic [15:0] q_round;
        bit          sat;
    } vec_t;
    vec_t vt [10];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] scale(input longint acc, input int rnd, output bit clamp);
        longint s;
        if (rnd != 0) acc = acc + 64'sd32768;
        s = acc >>> 16;
        clamp = 1'b0;
        if (s > 64'sd32767) begin
            s = 64'sd32767;
            clamp = 1'b1;
        end else if (s < -64'sd32768) begin
            s = -64'sd32768;
            clamp = 1'b1;
        end
        return s[15:0];
    endfunction

    task automatic model_edge();
        int a_eff;
        bit we_eff;
        bit c;
        longint sum;
        logic [15:0] v;
        if (!rst) begin
            for (int d = 0; d < ND; d++) begin
                for (int k = 0; k < 64; k++) begin
                    hist[d][k] = 0;
                    cm[d][k]   = 0;
                end
                fill_m[d] = 0;
                sat_m[d]  = 1'b0;
                fd_m[d]   = '0;
            end
            pq.delete();
            return;
        end
        for (int d = 0; d < ND; d++) begin
            a_eff  = int'(caddr) & ((1 << aw_m[d]) - 1);
            we_eff = cwe && (d != 1 || caddr < 8'd4);
            if (we_eff && a_eff < taps_m[d]) cm[d][a_eff] = longint'(cdat);
        end
        if (clr) begin
            for (int d = 0; d < ND; d++) begin
                for (int k = 0; k < 64; k++) hist[d][k] = 0;
                fill_m[d] = 0;
            end
            pq.delete();
        end else if (dv) begin
            for (int d = 0; d < ND; d++) begin
                for (int k = taps_m[d] - 1; k > 0; k--) hist[d][k] = hist[d][k-1];
                hist[d][0] = longint'(din);
                if (fill_m[d] < taps_m[d]) fill_m[d]++;
                if (fill_m[d] == taps_m[d]) begin
                    sum = 0;
                    for (int k = 0; k < taps_m[d]; k++) sum += hist[d][k] * cm[d][k];
                    v = scale(sum, rnd_m[d], c);
                    pq.push_back('{d, cyc + 2, v, c});
                end
            end
        end
    endtask

    task automatic check_all();
        bit ev;
        bit ev_c;
        logic [15:0] ev_val;
        pend_t keep[$];
        for (int d = 0; d < ND; d++) begin
            ev = 1'b0;
            ev_c = 1'b0;
            ev_val = '0;
            foreach (pq[i]) begin
                if (pq[i].d == d && pq[i].due == cyc) begin
                    ev = 1'b1;
                    ev_val = pq[i].val;
                    ev_c = pq[i].clamp;
                end
            end
            if (ev) begin
                fd_m[d] = ev_val;
                if (ev_c) sat_m[d] = 1'b1;
            end
            chk($sformatf("fir_valid[%0d]", d), longint'(ov[d]), longint'(ev));
            chk($sformatf("fir_d[%0d]", d), longint'(od[d]), longint'(fd_m[d]));
            chk($sformatf("sat_flag[%0d]", d), longint'(os[d]), longint'(sat_m[d]));
            if (ov[d]) pulses[d]++;
        end
        if (ov[1]) cap_b.push_back(od[1]);
        foreach (pq[i]) if (pq[i].due > cyc) keep.push_back(pq[i]);
        pq = keep;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b0; dv = 1'b0; clr = 1'b0; cwe = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic write_coef(input int a, input logic signed [19:0] v);
        cwe = 1'b1; caddr = 8'(a); cdat = v;
        step();
        cwe = 1'b0;
    endtask

    task automatic feed(input logic signed [15:0] d);
        dv = 1'b1; din = d;
        step();
        dv = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{16'h0180, 20'h00100, 16'h0001, 16'h0002, 1'b0};
        vt[1] = '{16'hFE80, 20'h00100, 16'hFFFE, 16'hFFFF, 1'b0};
        vt[2] = '{16'h0100, 20'h10000, 16'h0100, 16'h0100, 1'b0};
        vt[3] = '{16'h7FFF, 20'h7FFFF, 16'h7FFF, 16'h7FFF, 1'b1};
        vt[4] = '{16'h8000, 20'h7FFFF, 16'h8000, 16'h8000, 1'b1};
        vt[5] = '{16'h0001, 20'h08000, 16'h0000, 16'h0001, 1'b0};
        vt[6] = '{16'hFFFF, 20'h08000, 16'hFFFF, 16'h0000, 1'b0};
        vt[7] = '{16'h7FFF, 20'h10000, 16'h7FFF, 16'h7FFF, 1'b0};
        vt[8] = '{16'h8000, 20'h10000, 16'h8000, 16'h8000, 1'b0};
        vt[9] = '{16'h4000, 20'h20000, 16'h7FFF, 16'h7FFF, 1'b1};

        // Reset state
        do_reset();
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("reset_valid[%0d]", d), longint'(ov[d]), 0);
            chk($sformatf("reset_fir_d[%0d]", d), longint'(od[d]), 0);
            chk($sformatf("reset_sat[%0d]", d), longint'(os[d]), 0);
        end

        // Scaling, rounding and saturation vectors (only c[0] non-zero)
        for (int i = 0; i < 10; i++) begin
            do_reset();
            write_coef(0, vt[i].c0);
            for (int s = 0; s < 32; s++) feed(vt[i].d);
            step();
            step();
            chk($sformatf("vec%0d_floor_a", i), longint'(od[0]), longint'(vt[i].q_floor));
            chk($sformatf("vec%0d_round_b", i), longint'(od[1]), longint'(vt[i].q_round));
            chk($sformatf("vec%0d_floor_c", i), longint'(od[2]), longint'(vt[i].q_floor));
            for (int d = 0; d < ND; d++)
                chk($sformatf("vec%0d_sat[%0d]", i, d), longint'(os[d]), longint'(vt[i].sat));
            $display("vec %0d: data=%h c0=%h -> a=%h b=%h c=%h sat=%b%b%b",
                     i, vt[i].d, vt[i].c0, od[0], od[1], od[2], os[0], os[1], os[2]);
        end
        // sat_flag survives clear
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("sat_after_clear", longint'(os[0]), 1);
        chk("valid_after_clear", longint'(ov[0]), 0);
        $display("clear after saturation: sat=%b valid=%b", os[0], ov[0]);

        // All taps 1.0, 32 samples of 1.0 -> first output two edges after sample 32
        do_reset();
        for (int k = 0; k < 32; k++) write_coef(k, 20'sh10000);
        pulses[0] = 0;
        for (int s = 0; s < 32; s++) feed(16'sh0100);
        step();
        chk("warmup_pulses_before", longint'(pulses[0]), 0);
        step();
        chk("warmup_first_valid", longint'(ov[0]), 1);
        chk("warmup_first_fir_d", longint'(od[0]), 64'h2000);
        $display("warm-up: first output fir_d=%h", od[0]);

        // Impulse through {1.0, 0.5, 0.25, 0} on the 4-tap instance
        do_reset();
        write_coef(0, 20'sh10000);
        write_coef(1, 20'sh08000);
        write_coef(2, 20'sh04000);
        write_coef(3, 20'sh00000);
        cap_b.delete();
        for (int s = 0; s < 3; s++) feed(16'sh0000);
        feed(16'sh0100);
        for (int s = 0; s < 3; s++) feed(16'sh0000);
        step();
        step();
        chk("impulse_count", longint'(cap_b.size()), 4);
        if (cap_b.size() == 4) begin
            chk("impulse_0", longint'(cap_b[0]), 64'h0100);
            chk("impulse_1", longint'(cap_b[1]), 64'h0080);
            chk("impulse_2", longint'(cap_b[2]), 64'h0040);
            chk("impulse_3", longint'(cap_b[3]), 64'h0000);
        end
        $display("impulse: %0d outputs captured", cap_b.size());

        // clear coincident with sample 40 drops it and restarts warm-up
        do_reset();
        for (int k = 0; k < 32; k++) write_coef(k, 20'((k + 1) * 'h800));
        for (int s = 0; s < 39; s++) feed(16'($urandom_range(0, 1023)) - 16'sd512);
        clr = 1'b1;
        feed(16'sh1234);
        clr = 1'b0;
        pulses[0] = 0;
        for (int s = 0; s < 31; s++) feed(16'($urandom_range(0, 1023)) - 16'sd512);
        feed(16'sh0200);
        step();
        chk("clear_gap_pulses", longint'(pulses[0]), 0);
        step();
        chk("clear_restart_valid", longint'(ov[0]), 1);
        $display("clear+sample: restart output fir_d=%h", od[0]);

        // Reset with two outputs in flight on the 4-tap instance
        do_reset();
        for (int k = 0; k < 4; k++) write_coef(k, 20'sh10000);
        for (int s = 0; s < 6; s++) feed(16'sh0100);
        rst = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("async_rst_valid[%0d]", d), longint'(ov[d]), 0);
            chk($sformatf("async_rst_fir_d[%0d]", d), longint'(od[d]), 0);
        end
        step();
        step();
        rst = 1'b1;
        pulses[1] = 0;
        for (int s = 0; s < 4; s++) step();
        chk("rst_inflight_pulses", longint'(pulses[1]), 0);
        chk("rst_fir_d_zero", longint'(od[1]), 0);
        $display("mid-stream reset: pulses after release=%0d", pulses[1]);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            dv  = ($urandom_range(0, 3) != 0);
            din = ($urandom_range(0, 9) == 0) ? 16'($urandom)
                                              : 16'($urandom_range(0, 2047)) - 16'sd1024;
            cwe   = ($urandom_range(0, 7) == 0);
            caddr = 8'($urandom_range(0, 31));
            cdat  = ($urandom_range(0, 9) == 0) ? 20'($urandom)
                                                : 20'($urandom_range(0, 65535)) - 20'sd32768;
            clr   = ($urandom_range(0, 199) == 0);
            step();
        end
        dv = 1'b0; cwe = 1'b0; clr = 1'b0;
        step();
        step();
        $display("random: 2000 cycles applied");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
